// File: rtl/font_glyph_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : font_glyph_blitter
//  Description : Renders one glyph per command. Walks the CHAR_W x CHAR_H
//                glyph cell in raster order, addresses the font ROM reader,
//                samples its same-cycle is_character result and emits clipped,
//                coloured pixel writes over a valid/ready handshake.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                cmd_*_i / cmd_ready_o - glyph command (char, x, y, fg, bg)
//                font_*_o / font_pixel_i - font ROM reader address / result
//                px_*_o / px_ready_i - framebuffer pixel write handshake
//                busy_o, done_o      - status (busy accept..DONE, done pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module font_glyph_blitter #(
  parameter int CHAR_W         = 17,
  parameter int CHAR_H         = 17,
  parameter int SCREEN_W       = 320,
  parameter int SCREEN_H       = 240,
  parameter int COLOR_W        = 8,
  parameter bit TRANSPARENT_BG = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic [7:0]                  cmd_char_i,
  input  logic [$clog2(SCREEN_W)-1:0] cmd_x_i,
  input  logic [$clog2(SCREEN_H)-1:0] cmd_y_i,
  input  logic [COLOR_W-1:0]          cmd_fg_i,
  input  logic [COLOR_W-1:0]          cmd_bg_i,
  output logic [7:0]                  font_char_o,
  output logic [$clog2(CHAR_W)-1:0]   font_x_o,
  output logic [$clog2(CHAR_H)-1:0]   font_y_o,
  input  logic                        font_pixel_i,
  output logic                        px_valid_o,
  input  logic                        px_ready_i,
  output logic [$clog2(SCREEN_W)-1:0] px_x_o,
  output logic [$clog2(SCREEN_H)-1:0] px_y_o,
  output logic [COLOR_W-1:0]          px_color_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int XW  = $clog2(SCREEN_W);
  localparam int YW  = $clog2(SCREEN_H);
  localparam int GXW = $clog2(CHAR_W);
  localparam int GYW = $clog2(CHAR_H);

  // Screen-limit constants are one bit wider than the coordinates so the
  // origin + offset sum can never wrap back onto the visible screen.
  localparam logic [XW:0]    c_screen_w = (XW+1)'(SCREEN_W);
  localparam logic [YW:0]    c_screen_h = (YW+1)'(SCREEN_H);
  localparam logic [GXW-1:0] c_gx_last  = GXW'(CHAR_W - 1);
  localparam logic [GYW-1:0] c_gy_last  = GYW'(CHAR_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_EMIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           char_q, char_d;
  logic [XW-1:0]        ox_q, ox_d;
  logic [YW-1:0]        oy_q, oy_d;
  logic [COLOR_W-1:0]   fg_q, fg_d;
  logic [COLOR_W-1:0]   bg_q, bg_d;
  logic [GXW-1:0]       gx_q, gx_d;
  logic [GYW-1:0]       gy_q, gy_d;
  logic [XW-1:0]        px_x_q, px_x_d;
  logic [YW-1:0]        px_y_q, px_y_d;
  logic [COLOR_W-1:0]   px_color_q, px_color_d;

  logic [XW:0]          sx_w;
  logic [YW:0]          sy_w;
  logic                 emit_w;
  logic                 last_w;
  logic                 row_end_w;
  logic [GXW-1:0]       gx_adv_w;
  logic [GYW-1:0]       gy_adv_w;

  assign sx_w      = {1'b0, ox_q} + (XW+1)'(gx_q);
  assign sy_w      = {1'b0, oy_q} + (YW+1)'(gy_q);
  assign emit_w    = (font_pixel_i || !TRANSPARENT_BG) &&
                     (sx_w < c_screen_w) && (sy_w < c_screen_h);
  assign row_end_w = (gx_q == c_gx_last);
  assign last_w    = row_end_w && (gy_q == c_gy_last);
  assign gx_adv_w  = row_end_w ? '0 : gx_q + 1'b1;
  assign gy_adv_w  = row_end_w ? gy_q + 1'b1 : gy_q;

  // The ROM reader is driven straight from the cell walker registers.
  assign font_char_o = char_q;
  assign font_x_o    = gx_q;
  assign font_y_o    = gy_q;

  assign px_x_o      = px_x_q;
  assign px_y_o      = px_y_q;
  assign px_color_o  = px_color_q;
  assign px_valid_o  = (state_q == S_EMIT);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  // Held low while reset is asserted so nothing is accepted during reset.
  assign cmd_ready_o = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d    = state_q;
    char_d     = char_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    gx_d       = gx_q;
    gy_d       = gy_q;
    px_x_d     = px_x_q;
    px_y_d     = px_y_q;
    px_color_d = px_color_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          char_d  = cmd_char_i;
          ox_d    = cmd_x_i;
          oy_d    = cmd_y_i;
          fg_d    = cmd_fg_i;
          bg_d    = cmd_bg_i;
          gx_d    = '0;
          gy_d    = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (emit_w) begin
          // Cell position is held; it advances once the pixel is taken.
          px_x_d     = sx_w[XW-1:0];
          px_y_d     = sy_w[YW-1:0];
          px_color_d = font_pixel_i ? fg_q : bg_q;
          state_d    = S_EMIT;
        end else if (last_w) begin
          state_d = S_DONE;
        end else begin
          gx_d = gx_adv_w;
          gy_d = gy_adv_w;
        end
      end
      S_EMIT: begin
        if (px_ready_i) begin
          if (last_w) begin
            state_d = S_DONE;
          end else begin
            gx_d    = gx_adv_w;
            gy_d    = gy_adv_w;
            state_d = S_SCAN;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      char_q     <= '0;
      ox_q       <= '0;
      oy_q       <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      gx_q       <= '0;
      gy_q       <= '0;
      px_x_q     <= '0;
      px_y_q     <= '0;
      px_color_q <= '0;
    end else begin
      state_q    <= state_d;
      char_q     <= char_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      gx_q       <= gx_d;
      gy_q       <= gy_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
      px_color_q <= px_color_d;
    end
  end

endmodule
`default_nettype wire
